// File: rtl/cpu_hazard_pkg.sv
// Shared definitions for the ID-stage hazard controller and the EX-stage
// forwarding logic: controller state encoding, register index width and the
// default hardwired-zero register index.
package cpu_hazard_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic [REG_IDX_W-1:0] ZERO_REG_DEFAULT = '0;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for performance statistics.
//   clk   : clock, rising edge
//   arst  : asynchronous active-high reset, clears count
//   inc   : add one this cycle (ignored once the counter is full)
//   count : current value, sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_detection_unit.sv
// ID-stage hazard controller.
// Detects load-use hazards that forwarding cannot cover and stalls PC/IF-ID
// while bubbling ID/EX for LOAD_USE_STALLS cycles; squashes IF/ID and ID/EX on
// a taken branch resolved in EX. Counts bubble cycles and flush events.
//   clk, arst              : clock / async active-high reset
//   enable                 : global pipeline advance (low freezes everything)
//   register_rs1/rs2_IFID  : sources of the ID instruction, uses_rs2_IFID qualifies rs2
//   register_rd_IDEX       : destination of the EX instruction, memread_IDEX = it is a load
//   branch_taken_EX        : taken branch resolved in EX this cycle
//   pc_write, ifid_write   : load enables for PC and IF/ID
//   idex_bubble            : zero ID/EX control fields
//   ifid_flush             : clear IF/ID to NOP
//   stall_cycles           : saturating count of bubble cycles
//   flush_events           : saturating count of taken-branch flushes
module hazard_detection_unit
    import cpu_hazard_pkg::*;
#(
    parameter int                   LOAD_USE_STALLS = 1,
    parameter logic [REG_IDX_W-1:0] ZERO_REG        = ZERO_REG_DEFAULT,
    parameter int                   CNT_W           = 32
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 enable,
    input  logic [REG_IDX_W-1:0] register_rs1_IFID,
    input  logic [REG_IDX_W-1:0] register_rs2_IFID,
    input  logic                 uses_rs2_IFID,
    input  logic [REG_IDX_W-1:0] register_rd_IDEX,
    input  logic                 memread_IDEX,
    input  logic                 branch_taken_EX,
    output logic                 pc_write,
    output logic                 ifid_write,
    output logic                 idex_bubble,
    output logic                 ifid_flush,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_events
);

    // The first bubble is issued from RUN, so STALL covers the remaining ones.
    localparam logic [2:0] REM_INIT = 3'(LOAD_USE_STALLS - 1);
    localparam bit         MULTI    = (LOAD_USE_STALLS > 1);

    hz_state_e  state_q, state_d;
    logic [2:0] rem_q, rem_d;
    logic       hz;
    logic       stall_inc;
    logic       flush_inc;

    assign hz = memread_IDEX
              & (register_rd_IDEX != ZERO_REG)
              & ((register_rd_IDEX == register_rs1_IFID)
                 | (uses_rs2_IFID & (register_rd_IDEX == register_rs2_IFID)));

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        if (arst) begin
            // Outputs pinned to the free-running pattern while in reset.
        end else if (!enable) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (branch_taken_EX) begin
            // Branch wins over any hazard or pending stall.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = RUN;
            rem_d       = '0;
            flush_inc   = 1'b1;
        end else if (state_q == STALL) begin
            // Hazard is not re-evaluated: the load is still in flight.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
            if (rem_q <= 3'd1) begin
                state_d = RUN;
                rem_d   = '0;
            end else begin
                rem_d = rem_q - 3'd1;
            end
        end else if (hz) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
            if (MULTI) begin
                state_d = STALL;
                rem_d   = REM_INIT;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= RUN;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .arst  (arst),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .arst  (arst),
        .inc   (flush_inc),
        .count (flush_events)
    );

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench: three instances share stimulus.
//   u1: LOAD_USE_STALLS=1, CNT_W=32
//   u3: LOAD_USE_STALLS=3, CNT_W=32
//   u4: LOAD_USE_STALLS=1, CNT_W=4 (saturation)
module tb_hazard_detection_unit;

    logic       clk = 1'b0;
    logic       arst;
    logic       enable;
    logic [4:0] rs1, rs2, rd;
    logic       uses_rs2, memread, br;

    logic pc1, if1, bb1, fl1;
    logic pc3, if3, bb3, fl3;
    logic pc4, if4, bb4, fl4;
    logic [31:0] st1, fe1, st3, fe3;
    logic [3:0]  st4, fe4;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    hazard_detection_unit #(.LOAD_USE_STALLS(1), .CNT_W(32)) u1 (
        .clk(clk), .arst(arst), .enable(enable),
        .register_rs1_IFID(rs1), .register_rs2_IFID(rs2), .uses_rs2_IFID(uses_rs2),
        .register_rd_IDEX(rd), .memread_IDEX(memread), .branch_taken_EX(br),
        .pc_write(pc1), .ifid_write(if1), .idex_bubble(bb1), .ifid_flush(fl1),
        .stall_cycles(st1), .flush_events(fe1));

    hazard_detection_unit #(.LOAD_USE_STALLS(3), .CNT_W(32)) u3 (
        .clk(clk), .arst(arst), .enable(enable),
        .register_rs1_IFID(rs1), .register_rs2_IFID(rs2), .uses_rs2_IFID(uses_rs2),
        .register_rd_IDEX(rd), .memread_IDEX(memread), .branch_taken_EX(br),
        .pc_write(pc3), .ifid_write(if3), .idex_bubble(bb3), .ifid_flush(fl3),
        .stall_cycles(st3), .flush_events(fe3));

    hazard_detection_unit #(.LOAD_USE_STALLS(1), .CNT_W(4)) u4 (
        .clk(clk), .arst(arst), .enable(enable),
        .register_rs1_IFID(rs1), .register_rs2_IFID(rs2), .uses_rs2_IFID(uses_rs2),
        .register_rd_IDEX(rd), .memread_IDEX(memread), .branch_taken_EX(br),
        .pc_write(pc4), .ifid_write(if4), .idex_bubble(bb4), .ifid_flush(fl4),
        .stall_cycles(st4), .flush_events(fe4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Outputs packed as {pc_write, ifid_write, idex_bubble, ifid_flush}.
    task automatic chk_o1(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, pc1, if1, bb1, fl1}, {28'd0, exp});
    endtask
    task automatic chk_o3(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, pc3, if3, bb3, fl3}, {28'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        memread = 0; br = 0; uses_rs2 = 0; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3;
    endtask

    // Pulse reset between edges (called right after tick()).
    task automatic do_reset();
        arst = 1; #1; arst = 0; #1;
    endtask

    initial begin
        enable = 1; br = 0;
        // Hazard present during reset: outputs must still be free-running.
        arst = 1; memread = 1; rd = 5'd5; rs1 = 5'd5; rs2 = 5'd0; uses_rs2 = 0;
        #2;
        chk_o1("reset_outputs", 4'b1100);
        chk("reset_stall_cnt", st1, 32'd0);
        chk("reset_flush_cnt", fe3, 32'd0);
        tick(); tick();
        arst = 0; idle(); #1;

        // Load-use on rs1, single bubble.
        memread = 1; rd = 5'd5; rs1 = 5'd5; #1;
        chk_o1("lu_rs1_bubble", 4'b0010);
        tick(); idle(); #1;
        chk_o1("lu_rs1_back_run", 4'b1100);
        chk("lu_rs1_stall_cnt", st1, 32'd1);

        // No false hazards.
        do_reset();
        memread = 1; rd = 5'd0; rs1 = 5'd0; #1;
        chk_o1("nofalse_zero_reg", 4'b1100);
        tick();
        memread = 1; rd = 5'd7; rs1 = 5'd3; rs2 = 5'd7; uses_rs2 = 0; #1;
        chk_o1("nofalse_rs2_unused", 4'b1100);
        tick();
        memread = 0; rd = 5'd9; rs1 = 5'd9; #1;
        chk_o1("nofalse_not_load", 4'b1100);
        tick();
        chk("nofalse_stall_cnt", st1, 32'd0);

        // Branch in RUN with a simultaneous hazard: branch wins.
        memread = 1; rd = 5'd6; rs1 = 5'd6; br = 1; #1;
        chk_o1("run_branch_outputs", 4'b1111);
        tick(); idle(); #1;
        chk("run_branch_flush_cnt", fe1, 32'd1);
        chk("run_branch_stall_cnt", st1, 32'd0);

        // Multi-cycle stall on rs2.
        do_reset();
        memread = 1; rd = 5'd12; rs1 = 5'd1; rs2 = 5'd12; uses_rs2 = 1; #1;
        chk_o3("multi_b1", 4'b0010);
        tick(); idle(); #1;
        chk_o3("multi_b2", 4'b0010);
        tick();
        chk_o3("multi_b3", 4'b0010);
        tick();
        chk_o3("multi_done", 4'b1100);
        chk("multi_stall_cnt", st3, 32'd3);

        // Branch in the second stall cycle.
        tick(); do_reset();
        memread = 1; rd = 5'd12; rs1 = 5'd12; #1;
        chk_o3("brstall_b1", 4'b0010);
        tick(); idle(); br = 1; #1;
        chk_o3("brstall_flush", 4'b1111);
        tick(); br = 0; #1;
        chk_o3("brstall_run", 4'b1100);
        chk("brstall_stall_cnt", st3, 32'd1);
        chk("brstall_flush_cnt", fe3, 32'd1);

        // enable=0 mid-stall, then async reset mid-stall.
        tick(); do_reset();
        memread = 1; rd = 5'd8; rs1 = 5'd8; #1;
        tick(); idle(); enable = 0; #1;
        chk_o3("frz_outputs", 4'b0000);
        tick(); tick();
        chk_o3("frz_outputs_held", 4'b0000);
        chk("frz_stall_cnt", st3, 32'd1);
        enable = 1; #1;
        chk_o3("frz_resume_stall", 4'b0010);
        tick();
        chk("frz_resume_cnt", st3, 32'd2);
        chk_o3("frz_still_stall", 4'b0010);
        arst = 1; #1;
        chk_o3("arst_outputs", 4'b1100);
        chk("arst_stall_cnt", st3, 32'd0);
        arst = 0; #1;
        chk_o3("arst_run", 4'b1100);

        // Saturation: 20 back-to-back hazards.
        tick(); do_reset();
        memread = 1; rd = 5'd4; rs1 = 5'd4;
        for (int i = 0; i < 20; i++) tick();
        idle(); #1;
        chk("sat_cnt4", {28'd0, st4}, 32'd15);
        chk("sat_cnt32", st1, 32'd20);
        tick();
        chk("sat_hold", {28'd0, st4}, 32'd15);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
- Pipeline hazard controller in the ID stage. It sits upstream of the EX-stage forwarding logic.
- Detects load-use hazards that forwarding cannot resolve. It freezes PC and IF/ID, and injects bubbles into ID/EX for a configurable number of cycles.
- Squashes IF/ID and ID/EX on a taken branch resolved in EX.
- Keeps saturating performance counters for stall cycles and flush events.

Parameters:
- LOAD_USE_STALLS, 1, bubble cycles per load-use hazard (1..7). Above 1 models a multi-cycle data memory.
- ZERO_REG, 0, hardwired-zero register index; it never creates a hazard.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  core clock, rising edge.
- arst  in  1  reset, asynchronous, active-high.
- enable  in  1  global pipeline advance. Low means the whole core is frozen.
- register_rs1_IFID  in  5  source register 1 of the instruction in ID.
- register_rs2_IFID  in  5  source register 2 of the instruction in ID.
- uses_rs2_IFID  in  1  ID instruction actually reads rs2 (R-type, store, branch).
- register_rd_IDEX  in  5  destination register of the instruction in EX.
- memread_IDEX  in  1  EX instruction is a load.
- branch_taken_EX  in  1  branch in EX resolved taken this cycle.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register load enable.
- idex_bubble  out  1  zero the ID/EX control fields this cycle.
- ifid_flush  out  1  clear IF/ID to NOP.
- stall_cycles  out  CNT_W  count of bubble cycles inserted.
- flush_events  out  CNT_W  count of taken-branch flushes.

Behaviour:
- States: RUN, STALL. Counter rem, 3 bits.
- Reset: state=RUN, rem=0, both counters 0.
  - While arst is high, outputs are forced to pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0.
- Hazard definition: hz = memread_IDEX & (register_rd_IDEX != ZERO_REG) & ((register_rd_IDEX == register_rs1_IFID) | (uses_rs2_IFID & (register_rd_IDEX == register_rs2_IFID))).
- Outputs are combinational, with zero-cycle latency.
- RUN, branch_taken_EX=1:
  - Outputs: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1.
  - hz is ignored. Next state RUN. flush_events increments.
- RUN, hz=1, no branch:
  - Outputs: pc_write=0, ifid_write=0, idex_bubble=1.
  - If LOAD_USE_STALLS==1, next state is RUN. Otherwise next state is STALL with rem=LOAD_USE_STALLS-1.
  - stall_cycles increments.
- RUN, neither: pc_write=1, ifid_write=1, others 0.
- STALL, no branch:
  - Outputs: pc_write=0, ifid_write=0, idex_bubble=1. hz is not re-evaluated.
  - rem decrements. When rem reaches 1 the next state is RUN.
  - stall_cycles increments.
- STALL, branch_taken_EX=1: branch wins.
  - Flush outputs are driven exactly as in RUN.
  - rem is cleared, next state is RUN, flush_events increments. The stall is abandoned.
- enable=0:
  - State, rem and counters hold.
  - Outputs are pc_write=0, ifid_write=0, idex_bubble=0, ifid_flush=0.
- Counters: saturate at 2^CNT_W-1 with no wrap. Each counter increments at most 1 per cycle.
- arst asserted mid-STALL: returns to RUN immediately, asynchronously. No pending bubbles survive reset.

Decomposition:
- Package cpu_hazard_pkg holds the state enum (RUN, STALL), the ZERO_REG default, and the REG_IDX_W=5 constant. It is shared with the forwarding logic.
- One sub-module, sat_counter, parameterised by width, with ports clk, arst, inc, and count. It is instantiated twice.

Test Plan:
- Load-use on rs1:
  - Stimulus: memread_IDEX=1, rd_IDEX=5, rs1_IFID=5, LOAD_USE_STALLS=1.
  - Required: exactly 1 cycle with pc_write=0, ifid_write=0, idex_bubble=1, then back to RUN. stall_cycles=1.
- No false hazards:
  - Case A: rd_IDEX=ZERO_REG with rs1 matching.
  - Case B: rs2 matching with uses_rs2_IFID=0.
  - Case C: memread_IDEX=0 with a match.
  - Required in all three: pc_write=1, stall_cycles stays 0.
- Multi-cycle stall:
  - Stimulus: LOAD_USE_STALLS=3, hazard on rs2 with uses_rs2=1.
  - Required: 3 consecutive bubble cycles, ifid_write=0 throughout. stall_cycles=3.
- Branch during stall:
  - Stimulus: LOAD_USE_STALLS=3, branch_taken_EX=1 in the 2nd stall cycle.
  - Required: that cycle shows ifid_flush=1 and pc_write=1; the next cycle is in RUN. stall_cycles=1, flush_events=1.
- enable=0 mid-STALL, then arst:
  - Required: state and counters frozen while enable=0, all hazard outputs 0.
  - On arst pulse, outputs go immediately to pc_write=1, ifid_write=1 and counters clear to 0.
- Saturation:
  - Stimulus: CNT_W=4, 20 back-to-back hazards.
  - Required: stall_cycles holds at 15.
